// File: rtl/dmem_lsu_if.sv
// Core-side load/store bus of the data-memory LSU: request, store data and
// the registered response. The core is the master, the LSU the slave.
interface dmem_lsu_if;
  logic        req_i;
  logic        we_i;
  logic [15:0] addr_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit in front of four byte-lane RAMs. Optionally
// zero-fills the whole memory after reset, then serves one access per cycle:
// stores become per-lane write enables, loads are lane-selected, extended
// and returned one cycle after acceptance.
module dmem_lsu #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int DEPTH_WORDS    = 16384
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_lsu_if.slave   bus,
  output logic [13:0] lane_addr_o,
  output logic [3:0]  lane_wren_o,
  output logic [31:0] lane_wdata_o,
  input  logic [31:0] lane_rdata_i
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  localparam logic [13:0] CLR_LAST = 14'(DEPTH_WORDS - 1);

  state_t      state_q, state_d;
  logic [13:0] clr_cnt_q;
  logic        legal;
  logic        accept;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  // Alignment legality of the presented access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal = 1'b0;
    unique case (bus.size_i)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~bus.addr_i[0];
      2'b10:   legal = (bus.addr_i[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && !rst_i && bus.req_i;

  // Store lane mask and replicated store data for the addressed lanes.
  always_comb begin
    st_mask = 4'b0000;
    st_data = bus.wdata_i;
    unique case (bus.size_i)
      2'b00: begin
        st_mask = 4'b0001 << bus.addr_i[1:0];
        st_data = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        st_mask = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.wdata_i[15:0]}};
      end
      2'b10:   st_mask = 4'b1111;
      default: st_mask = 4'b0000;
    endcase
  end

  // Load lane selection and sign/zero extension from the lane read data.
  always_comb begin
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        sx;
    ld_b = lane_rdata_i[7:0];
    unique case (bus.addr_i[1:0])
      2'b00: ld_b = lane_rdata_i[7:0];
      2'b01: ld_b = lane_rdata_i[15:8];
      2'b10: ld_b = lane_rdata_i[23:16];
      2'b11: ld_b = lane_rdata_i[31:24];
    endcase
    ld_h = bus.addr_i[1] ? lane_rdata_i[31:16] : lane_rdata_i[15:0];
    sx   = ~bus.unsigned_i;
    unique case (bus.size_i)
      2'b00:   ld_data = {{24{sx & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{sx & ld_h[15]}}, ld_h};
      default: ld_data = lane_rdata_i;
    endcase
  end

  // FSM next state and lane-side outputs; reset forces everything quiet.
  always_comb begin
    state_d      = state_q;
    bus.ready_o  = 1'b0;
    lane_addr_o  = bus.addr_i[15:2];
    lane_wren_o  = 4'b0000;
    lane_wdata_o = st_data;
    unique case (state_q)
      S_CLEAR: begin
        lane_addr_o  = clr_cnt_q;
        lane_wdata_o = 32'h0;
        lane_wren_o  = rst_i ? 4'b0000 : 4'b1111;
        if (clr_cnt_q == CLR_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        bus.ready_o = !rst_i;
        if (accept && bus.we_i && legal) lane_wren_o = st_mask;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and clear counter; reset restarts the clear from word 0.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt_q <= 14'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 14'd1;
    end
  end

  // Registered response: one beat per accepted request, data only for legal loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= accept;
      err_q    <= accept && !legal;
      rdata_q  <= (accept && !bus.we_i && legal) ? ld_data : 32'h0;
    end
  end

  // Hold the response at zero while reset is asserted, dropping any pending beat.
  assign bus.rvalid_o = rvalid_q && !rst_i;
  assign bus.err_o    = err_q && !rst_i;
  assign bus.rdata_o  = rst_i ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural four-lane RAM model.
module tb_dmem_lsu;
  localparam int DEPTH = 16384;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [13:0] lane_addr;
  logic [3:0]  lane_wren;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  dmem_lsu_if bus ();

  dmem_lsu #(.CLEAR_ON_RESET(1'b1), .DEPTH_WORDS(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .lane_addr_o  (lane_addr),
    .lane_wren_o  (lane_wren),
    .lane_wdata_o (lane_wdata),
    .lane_rdata_i (lane_rdata)
  );

  always #5 clk_i = ~clk_i;

  // Byte-lane RAMs: synchronous write, combinational read; seeded non-zero
  // so that the clear is observable.
  logic [7:0] mem [4][DEPTH];
  bit         seeded = 1'b0;

  always @(posedge clk_i) begin
    if (!seeded) begin
      for (int k = 0; k < 4; k++)
        for (int w = 0; w < DEPTH; w++) mem[k][w] <= 8'hA5;
      seeded <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (lane_wren[k]) mem[k][lane_addr] <= lane_wdata[8*k +: 8];
    end
  end

  assign lane_rdata = {mem[3][lane_addr], mem[2][lane_addr],
                       mem[1][lane_addr], mem[0][lane_addr]};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request and check the same-cycle lane-side outputs.
  task automatic issue(input logic we, input logic [15:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input logic [3:0] exp_wren, input logic [31:0] exp_wdata);
    bus.req_i      = 1'b1;
    bus.we_i       = we;
    bus.addr_i     = a;
    bus.size_i     = sz;
    bus.unsigned_i = u;
    bus.wdata_i    = wd;
    #1;
    check("ready", 32'(bus.ready_o), 32'd1);
    check("lane_wren", 32'(lane_wren), 32'(exp_wren));
    check("lane_addr", 32'(lane_addr), 32'(a[15:2]));
    if (exp_wren != 4'b0000) check("lane_wdata", lane_wdata, exp_wdata);
  endtask

  // Check the response one cycle after acceptance.
  task automatic resp(input logic exp_err, input logic [31:0] exp_rdata);
    check("rvalid", 32'(bus.rvalid_o), 32'd1);
    check("err", 32'(bus.err_o), 32'(exp_err));
    check("rdata", bus.rdata_o, exp_rdata);
  endtask

  // Walk n clear cycles, expecting addresses 0..n-1 with all lanes written,
  // no ready and no response even though requests are presented.
  task automatic clear_walk(input int n);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < n; i++) begin
      bus.req_i = (i < 100);
      #1;
      if (lane_addr !== 14'(i) || lane_wren !== 4'hF || lane_wdata !== 32'h0 ||
          bus.ready_o !== 1'b0 || bus.rvalid_o !== 1'b0) begin
        if (first < 0) first = i;
        bad++;
      end
      @(posedge clk_i);
    end
    #1;
    bus.req_i = 1'b0;
    check("clear_bad_cycles", 32'(bad), 32'd0);
    if (first >= 0) $display("first bad clear cycle %0d", first);
  endtask

  initial begin
    rst_i          = 1'b1;
    bus.req_i      = 1'b0;
    bus.we_i       = 1'b1;
    bus.addr_i     = 16'h0;
    bus.size_i     = 2'b10;
    bus.unsigned_i = 1'b0;
    bus.wdata_i    = 32'h0;

    // Reset state.
    tick(); tick(); tick();
    check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_wren", 32'(lane_wren), 32'd0);

    // Partial clear, then reset at count 5000.
    rst_i = 1'b0;
    clear_walk(5000);
    check("mid_clear_addr", 32'(lane_addr), 32'd5000);
    rst_i = 1'b1;
    #1;
    check("mid_rst_wren", 32'(lane_wren), 32'd0);
    check("mid_rst_ready", 32'(bus.ready_o), 32'd0);
    tick();
    rst_i = 1'b0;

    // Full clear restarting at word 0.
    clear_walk(DEPTH);
    check("post_clear_ready", 32'(bus.ready_o), 32'd1);
    check("post_clear_rvalid", 32'(bus.rvalid_o), 32'd0);

    // Cleared memory reads zero.
    issue(1'b0, 16'h1234, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'h0);

    // Word store, then byte/half loads.
    issue(1'b1, 16'h0100, 2'b10, 1'b0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF); tick(); resp(1'b0, 32'h0);
    issue(1'b0, 16'h0103, 2'b00, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'hFFFFFFDE);
    issue(1'b0, 16'h0102, 2'b01, 1'b1, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'h0000DEAD);
    issue(1'b0, 16'h0102, 2'b01, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'hFFFFDEAD);
    issue(1'b0, 16'h0100, 2'b00, 1'b1, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'h000000EF);

    // Sub-word stores into a known word.
    issue(1'b1, 16'h0204, 2'b10, 1'b0, 32'h11223344, 4'hF, 32'h11223344); tick(); resp(1'b0, 32'h0);
    issue(1'b1, 16'h0205, 2'b00, 1'b0, 32'h1234567F, 4'b0010, 32'h7F7F7F7F); tick(); resp(1'b0, 32'h0);
    issue(1'b0, 16'h0204, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'h11227F44);
    issue(1'b1, 16'h0206, 2'b01, 1'b0, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF); tick(); resp(1'b0, 32'h0);
    issue(1'b0, 16'h0204, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'hBEEF7F44);
    issue(1'b0, 16'h0204, 2'b01, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'h00007F44);

    // Misaligned and illegal accesses: error, no data, no lane write.
    issue(1'b0, 16'h0001, 2'b01, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b1, 32'h0);
    issue(1'b0, 16'h0006, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b1, 32'h0);
    issue(1'b1, 16'h0100, 2'b11, 1'b0, 32'hFFFFFFFF, 4'h0, 32'h0); tick(); resp(1'b1, 32'h0);
    issue(1'b1, 16'h0102, 2'b10, 1'b0, 32'h01234567, 4'h0, 32'h0); tick(); resp(1'b1, 32'h0);
    issue(1'b1, 16'h0101, 2'b01, 1'b0, 32'h00005555, 4'h0, 32'h0); tick(); resp(1'b1, 32'h0);
    issue(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, 32'hDEADBEEF);

    // Back-to-back store/load pairs to one word, no idle cycles.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'hA5000000 + 32'(i) * 32'h00010203;
      issue(1'b1, 16'h0300, 2'b10, 1'b0, d, 4'hF, d); tick(); resp(1'b0, 32'h0);
      issue(1'b0, 16'h0300, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0); tick(); resp(1'b0, d);
    end
    bus.req_i = 1'b0;
    #1;
    check("idle_wren", 32'(lane_wren), 32'd0);
    tick();
    check("no_req_rvalid", 32'(bus.rvalid_o), 32'd0);

    // Reset drops a pending response and restarts the clear.
    issue(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    bus.req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rst_drop_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_drop_rdata", bus.rdata_o, 32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_after_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("reclear_wren", 32'(lane_wren), 32'hF);
    check("reclear_addr", 32'(lane_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
